// File: rtl/cpu_reg_pkg.sv
// cpu_reg_pkg
//   Constants shared by the general-purpose register file and its scoreboard:
//   x86-style register indices, the EBX reset value and default dimensions.
package cpu_reg_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_NUM_REGS = 8;

  // x86 encoding order
  localparam int REG_EAX = 0;
  localparam int REG_ECX = 1;
  localparam int REG_EDX = 2;
  localparam int REG_EBX = 3;

  localparam logic [31:0] EBX_RESET = 32'h0000_0888;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Pending-write scoreboard for the register file. Decode reserves a
//   destination register, writeback releases it. Also reports per-read-port
//   busy status and a sticky flag for writes to unreserved registers.
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   rsv_en, rsv_addr        reserve (set pending) request
//   wr_en, wr_addr          writeback (clear pending) strobe
//   rd0_addr, rd1_addr      read port indices for busy lookup
//   err_clr                 clears err_unreserved
//   pending                 scoreboard vector
//   rd0_busy, rd1_busy      read port register has an outstanding write
//   err_unreserved          sticky: a write hit a non-pending register
module reg_scoreboard
  import cpu_reg_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [AW-1:0]       rd0_addr,
  input  logic [AW-1:0]       rd1_addr,
  input  logic                err_clr,
  output logic [NUM_REGS-1:0] pending,
  output logic                rd0_busy,
  output logic                rd1_busy,
  output logic                err_unreserved
);

  logic [NUM_REGS-1:0] pending_nxt;
  logic                err_nxt;

  // Release first, then reserve, so a same-cycle re-issue keeps the bit set.
  always_comb begin
    pending_nxt = pending;
    if (wr_en)  pending_nxt[wr_addr]  = 1'b0;
    if (rsv_en) pending_nxt[rsv_addr] = 1'b1;
  end

  // Set takes priority over clear.
  always_comb begin
    err_nxt = err_unreserved;
    if (wr_en && !pending[wr_addr]) err_nxt = 1'b1;
    else if (err_clr)               err_nxt = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending        <= '0;
      err_unreserved <= 1'b0;
    end else begin
      pending        <= pending_nxt;
      err_unreserved <= err_nxt;
    end
  end

  // A writeback landing this cycle satisfies the read.
  assign rd0_busy = pending[rd0_addr] && !(wr_en && (wr_addr == rd0_addr));
  assign rd1_busy = pending[rd1_addr] && !(wr_en && (wr_addr == rd1_addr));

endmodule

// File: rtl/gp_register_file.sv
// gp_register_file
//   Bank of NUM_REGS general-purpose registers, WIDTH bits each, with two
//   combinational read ports (same-cycle write-through bypass), one
//   byte-enabled write port and a pending-write scoreboard.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   rd0_addr/rd0_data/rd0_busy   read port 0
//   rd1_addr/rd1_data/rd1_busy   read port 1
//   rsv_en, rsv_addr             reserve a destination register
//   wr_en, wr_addr, wr_be,       writeback; wr_be bit i covers bits [8i+7:8i]
//   wr_data
//   pending                      scoreboard vector
//   err_unreserved, err_clr      sticky unreserved-write flag and its clear
module gp_register_file
  import cpu_reg_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [AW-1:0]        rd0_addr,
  output logic [WIDTH-1:0]     rd0_data,
  output logic                 rd0_busy,
  input  logic [AW-1:0]        rd1_addr,
  output logic [WIDTH-1:0]     rd1_data,
  output logic                 rd1_busy,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH/8-1:0]   wr_be,
  input  logic [WIDTH-1:0]     wr_data,
  output logic [NUM_REGS-1:0]  pending,
  output logic                 err_unreserved,
  input  logic                 err_clr
);

  localparam int NB = WIDTH / 8;
  // EBX reset value zero-extended or truncated to WIDTH.
  localparam logic [WIDTH-1:0] EBX_RST_W = WIDTH'(EBX_RESET);

  logic [WIDTH-1:0] regs [NUM_REGS];

  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] nxt,
                                                   input logic [NB-1:0]    be);
    logic [WIDTH-1:0] r;
    r = cur;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) r[8*i +: 8] = nxt[8*i +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        regs[n] <= (n == REG_EBX) ? EBX_RST_W : '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= merge_bytes(regs[wr_addr], wr_data, wr_be);
    end
  end

  always_comb begin
    rd0_data = regs[rd0_addr];
    if (wr_en && (wr_addr == rd0_addr)) rd0_data = merge_bytes(regs[rd0_addr], wr_data, wr_be);
  end

  always_comb begin
    rd1_data = regs[rd1_addr];
    if (wr_en && (wr_addr == rd1_addr)) rd1_data = merge_bytes(regs[rd1_addr], wr_data, wr_be);
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clock          (clock),
    .reset          (reset),
    .rsv_en         (rsv_en),
    .rsv_addr       (rsv_addr),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .rd0_addr       (rd0_addr),
    .rd1_addr       (rd1_addr),
    .err_clr        (err_clr),
    .pending        (pending),
    .rd0_busy       (rd0_busy),
    .rd1_busy       (rd1_busy),
    .err_unreserved (err_unreserved)
  );

endmodule
